// File: rtl/tri_dispatch_arbiter_pkg.sv
// Shared types for the triangle dispatch path:
// geometry/colour bundles and the dispatcher state encoding.
package tri_dispatch_arbiter_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D p;
    Vertex3D q;
    Vertex3D r;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } Color;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_LOAD,
    DS_ARB,
    DS_OFFER
  } DispatchState;

endpackage

// File: rtl/rr_lane_picker.sv
// Round-robin lane picker: first requesting lane after ptr,
// wrapping, as a one-hot grant plus a found flag.
module rr_lane_picker #(
  parameter int NUM_RAST = 4,
  localparam int PTR_W = $clog2(NUM_RAST)
) (
  input  logic [NUM_RAST-1:0] req_n,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_RAST-1:0] grant,
  output logic                found
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_RAST; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_RAST);
      if (!found && req_n[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_dispatch_arbiter.sv
// Triangle dispatcher: pops the texel assembler and offers each
// triangle to a free rasterizer lane. `DISPATCH_STATS_EN adds counters.
module tri_dispatch_arbiter
  import tri_dispatch_arbiter_pkg::*;
#(
  parameter int NUM_RAST = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      texel_ready,
  input  Triangle3D                 texel_vertices,
  input  Color                      texel_color,
  output logic                      texel_read,
  input  logic [NUM_RAST-1:0]       rast_busy,
  input  logic [NUM_RAST-1:0]       rast_accept,
  output logic [NUM_RAST-1:0]       rast_valid,
  output Triangle3D                 rast_vertices,
  output Color                      rast_color,
  output logic                      dispatch_idle,
  input  logic                      stats_clear,
  output logic [NUM_RAST*CNT_W-1:0] stats_count
);

  localparam int PTR_W = $clog2(NUM_RAST);

  DispatchState state_q, state_d;
  Triangle3D hold_vtx_q;
  Color hold_col_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] gnt_idx_q;
  logic [NUM_RAST-1:0] gnt_oh_q;
  logic [NUM_RAST-1:0] pick_oh;
  logic [PTR_W-1:0] pick_idx;
  logic pick_found;
  logic pop;
  logic accept_hit;

  rr_lane_picker #(
    .NUM_RAST(NUM_RAST)
  ) u_picker (
    .req_n(~rast_busy),
    .ptr  (ptr_q),
    .grant(pick_oh),
    .found(pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_RAST; i++) begin
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    end
  end

  // A ready drop or flush in LOAD leaves the triangle in the assembler.
  assign pop = (state_q == DS_LOAD) && texel_ready && !flush;
  assign accept_hit = (state_q == DS_OFFER)
                    && |(rast_accept & gnt_oh_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE:
        if (!flush && texel_ready && enable)
          state_d = DS_LOAD;
      DS_LOAD:
        state_d = pop ? DS_ARB : DS_IDLE;
      DS_ARB:
        if (flush)
          state_d = DS_IDLE;
        else if (pick_found)
          state_d = DS_OFFER;
      DS_OFFER:
        if (accept_hit || flush)
          state_d = DS_IDLE;
      default:
        state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DS_IDLE;
      hold_vtx_q <= '0;
      hold_col_q <= '0;
      ptr_q      <= PTR_W'(NUM_RAST - 1);
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        hold_vtx_q <= texel_vertices;
        hold_col_q <= texel_color;
      end
      if (state_q == DS_ARB && pick_found) begin
        gnt_oh_q  <= pick_oh;
        gnt_idx_q <= pick_idx;
      end
      if (accept_hit) ptr_q <= gnt_idx_q;
    end
  end

  assign texel_read    = pop;
  assign rast_valid    = (state_q == DS_OFFER) ? gnt_oh_q : '0;
  assign rast_vertices = hold_vtx_q;
  assign rast_color    = hold_col_q;
  assign dispatch_idle = (state_q == DS_IDLE);

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_RAST];

  always_ff @(posedge clk) begin
    if (rst || stats_clear) begin
      for (int i = 0; i < NUM_RAST; i++) cnt_q[i] <= '0;
    end else if (accept_hit) begin
      cnt_q[gnt_idx_q] <= cnt_q[gnt_idx_q] + 1'b1;
    end
  end

  always_comb begin
    stats_count = '0;
    for (int i = 0; i < NUM_RAST; i++)
      stats_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`else
  logic unused_stats;
  assign unused_stats = stats_clear;
  assign stats_count  = '0;
`endif

endmodule

// File: tb/tb_tri_dispatch_arbiter.sv
// Directed bench for tri_dispatch_arbiter (NUM_RAST=4, CNT_W=16).
// Stats expectations collapse to zero when DISPATCH_STATS_EN is off.
module tb_tri_dispatch_arbiter;
  import tri_dispatch_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int CW = 16;

  logic tb_clk = 1'b0;
  logic rst, enable, flush, texel_ready, stats_clear;
  Triangle3D texel_vertices, rast_vertices;
  Color texel_color, rast_color;
  logic texel_read, dispatch_idle;
  logic [NR-1:0] rast_busy, rast_accept, rast_valid;
  logic [NR*CW-1:0] stats_count;

  int n_vec = 0;
  int n_bad = 0;
  int waited;

  always #5 tb_clk = ~tb_clk;

  tri_dispatch_arbiter #(
    .NUM_RAST(NR),
    .CNT_W   (CW)
  ) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .enable        (enable),
    .flush         (flush),
    .texel_ready   (texel_ready),
    .texel_vertices(texel_vertices),
    .texel_color   (texel_color),
    .texel_read    (texel_read),
    .rast_busy     (rast_busy),
    .rast_accept   (rast_accept),
    .rast_valid    (rast_valid),
    .rast_vertices (rast_vertices),
    .rast_color    (rast_color),
    .dispatch_idle (dispatch_idle),
    .stats_clear   (stats_clear),
    .stats_count   (stats_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] st(int l3, int l2, int l1, int l0);
`ifdef DISPATCH_STATS_EN
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
`else
    return 64'd0;
`endif
  endfunction

  task automatic cyc();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic obs();
    @(negedge tb_clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    flush = 1'b0;
    texel_ready = 1'b0;
    stats_clear = 1'b0;
    rast_busy = '0;
    rast_accept = '0;
    texel_vertices = '0;
    texel_color = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Starts at an IDLE cycle; returns at the start of the first ARB exit cycle.
  task automatic load_tri(input logic [15:0] px, input logic [7:0] cr);
    texel_vertices = '0;
    texel_vertices.p.x = px;
    texel_color = '0;
    texel_color.r = cr;
    texel_ready = 1'b1;
    enable = 1'b1;
    obs();
    chk("idle_c0", dispatch_idle, 1);
    chk("read_c0", texel_read, 0);
    cyc();
    obs();
    chk("read_c1", texel_read, 1);
    cyc();
    texel_ready = 1'b0;
    obs();
    chk("valid_c2", rast_valid, 0);
    chk("read_c2", texel_read, 0);
    cyc();
  endtask

  task automatic take(input logic [NR-1:0] exp, input int budget,
                      output int w);
    w = 0;
    obs();
    while (rast_valid == '0 && w < budget) begin
      w++;
      cyc();
      obs();
    end
    chk("offer", rast_valid, exp);
  endtask

  task automatic accept(input logic [NR-1:0] lanes,
                        input logic [15:0] px);
    chk("bcast_x", rast_vertices.p.x, px);
    rast_accept = lanes;
    cyc();
    rast_accept = '0;
    obs();
    chk("idle_acc", dispatch_idle, 1);
    chk("valid_acc", rast_valid, 0);
    cyc();
  endtask

  initial begin
    do_reset();

    // enable low holds off the fetch
    texel_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      obs();
      chk("s1_read", texel_read, 0);
      chk("s1_idle", dispatch_idle, 1);
      chk("s1_valid", rast_valid, 0);
      chk("s1_stats", stats_count, 0);
      cyc();
    end
    texel_ready = 1'b0;

    // single triangle, all lanes free
    load_tri(16'h1100, 8'h22);
    take(4'b0001, 8, waited);
    chk("s2_lat", waited, 0);
    chk("s2_color", rast_color.r, 8'h22);
    accept(4'b0001, 16'h1100);
    chk("s2_stats", stats_count, st(0, 0, 0, 1));

    // four back-to-back with lane 1 busy
    do_reset();
    rast_busy = 4'b0010;
    load_tri(16'h0001, 8'h01);
    take(4'b0001, 8, waited);
    accept(4'b0001, 16'h0001);
    load_tri(16'h0002, 8'h02);
    take(4'b0100, 8, waited);
    accept(4'b0100, 16'h0002);
    load_tri(16'h0003, 8'h03);
    take(4'b1000, 8, waited);
    accept(4'b1000, 16'h0003);
    load_tri(16'h0004, 8'h04);
    take(4'b0001, 8, waited);
    accept(4'b0001, 16'h0004);
    chk("s3_stats", stats_count, st(1, 1, 0, 2));

    // all busy: parked in ARB
    rast_busy = 4'b1111;
    load_tri(16'h0044, 8'h44);
    for (int i = 0; i < 20; i++) begin
      obs();
      chk("s4_valid", rast_valid, 0);
      chk("s4_idle", dispatch_idle, 0);
      cyc();
    end
    rast_busy = 4'b1011;
    obs();
    chk("s4_still", rast_valid, 0);
    cyc();
    obs();
    chk("s4_grant", rast_valid, 4'b0100);
    // busy rise and stray accept do not disturb the offer
    rast_busy = 4'b1111;
    rast_accept = 4'b0001;
    cyc();
    rast_accept = '0;
    obs();
    chk("s4_hold", rast_valid, 4'b0100);
    rast_busy = '0;
    accept(4'b0100, 16'h0044);
    chk("s4_stats", stats_count, st(1, 2, 0, 2));

    // flush in OFFER without accept
    load_tri(16'h0055, 8'h55);
    take(4'b1000, 8, waited);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    obs();
    chk("s5_valid", rast_valid, 0);
    chk("s5_idle", dispatch_idle, 1);
    chk("s5_stats", stats_count, st(1, 2, 0, 2));
    cyc();

    // flush in LOAD suppresses the pop
    texel_vertices.p.x = 16'h0066;
    texel_ready = 1'b1;
    enable = 1'b1;
    cyc();
    flush = 1'b1;
    obs();
    chk("s5_ldread", texel_read, 0);
    cyc();
    flush = 1'b0;
    texel_ready = 1'b0;
    obs();
    chk("s5_ldidle", dispatch_idle, 1);
    chk("s5_kept", rast_vertices.p.x, 16'h0055);
    cyc();

    // flush coincident with accept: accept wins
    load_tri(16'h0077, 8'h77);
    take(4'b1000, 8, waited);
    rast_accept = 4'b1000;
    flush = 1'b1;
    cyc();
    rast_accept = '0;
    flush = 1'b0;
    obs();
    chk("fa_idle", dispatch_idle, 1);
    chk("fa_stats", stats_count, st(2, 2, 0, 2));
    cyc();

    // clear beats a same-cycle increment
    load_tri(16'h0088, 8'h88);
    take(4'b0001, 8, waited);
    rast_accept = 4'b0001;
    stats_clear = 1'b1;
    cyc();
    rast_accept = '0;
    stats_clear = 1'b0;
    obs();
    chk("clr_stats", stats_count, 0);
    cyc();

    // ready drop during LOAD
    texel_ready = 1'b1;
    cyc();
    texel_ready = 1'b0;
    obs();
    chk("drop_read", texel_read, 0);
    cyc();
    obs();
    chk("drop_idle", dispatch_idle, 1);
    cyc();

    // rst mid-operation restores pointer and registers
    load_tri(16'h0099, 8'h99);
    take(4'b0010, 8, waited);
    accept(4'b0010, 16'h0099);
    load_tri(16'h00aa, 8'haa);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    obs();
    chk("rst_idle", dispatch_idle, 1);
    chk("rst_valid", rast_valid, 0);
    chk("rst_vtx", rast_vertices, 0);
    chk("rst_col", rast_color, 0);
    chk("rst_stats", stats_count, 0);
    cyc();
    load_tri(16'h00bb, 8'hbb);
    take(4'b0001, 8, waited);
    accept(4'b0001, 16'h00bb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
